image_rom_streamer: RTL and testbench

- Pipelined pixel fetcher between VGA timing/pixel-coordinate logic and a synchronous image ROM (1-cycle read latency).
- Converts screen coordinates to ROM addresses, with these additions:
  - per-frame image origin;
  - power-of-two upscaling;
  - multi-image selection;
  - out-of-bounds background fill.
- Delivers one colour word per accepted pixel at a fixed latency, with a valid flag.

---
 rtl/image_rom_streamer.sv | 124 ++++++++++++
 tb/tb_image_rom_streamer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_rom_streamer.sv
// rtl/image_rom_streamer.sv - pipelined screen-coordinate to image-ROM pixel fetcher
module image_rom_streamer #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int NUM_IMG     = 1,
    parameter int SEL_W       = 1,
    parameter int COORD_W     = 10,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 12,
    parameter int SCALE_SHIFT = 0,
    parameter logic [DATA_W-1:0] BG_COLOR = {DATA_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic [SEL_W-1:0]   img_sel,
    input  logic [COORD_W-1:0] org_x,
    input  logic [COORD_W-1:0] org_y,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic               rgb_valid,
    output logic [DATA_W-1:0]  rgb_out
);

    localparam logic [ADDR_W-1:0] IMG_SIZE = ADDR_W'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] ROW_LEN  = ADDR_W'(IMG_W);

    logic [SEL_W-1:0]   sel_l;
    logic [COORD_W-1:0] ox_l, oy_l;

    logic [COORD_W:0]   dx, dy, sx, sy;
    logic               inb_c;

    logic               v1, inb1;
    logic [SEL_W-1:0]   sel1;
    logic [COORD_W-1:0] rx1, ry1;
    logic               v2, inb2, v3, inb3;
    logic [ADDR_W-1:0]  addr_c;

    // Out-of-range selects fall back to image 0 so the address never leaves the ROM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_l <= '0;
            ox_l  <= '0;
            oy_l  <= '0;
        end else if (frame_start) begin
            sel_l <= (32'(img_sel) < NUM_IMG) ? img_sel : '0;
            ox_l  <= org_x;
            oy_l  <= org_y;
        end
    end

    // The extra top bit of dx/dy is the borrow: set means the pixel is left of or above the origin.
    always_comb begin
        dx    = {1'b0, pix_x} - {1'b0, ox_l};
        dy    = {1'b0, pix_y} - {1'b0, oy_l};
        sx    = dx >> SCALE_SHIFT;
        sy    = dy >> SCALE_SHIFT;
        inb_c = !dx[COORD_W] && !dy[COORD_W] &&
                (32'(sx) < IMG_W) && (32'(sy) < IMG_H);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            inb1 <= 1'b0;
            sel1 <= '0;
            rx1  <= '0;
            ry1  <= '0;
        end else begin
            v1   <= pix_valid;
            inb1 <= inb_c;
            sel1 <= sel_l;
            rx1  <= sx[COORD_W-1:0];
            ry1  <= sy[COORD_W-1:0];
        end
    end

    assign addr_c = ADDR_W'(sel1) * IMG_SIZE + ADDR_W'(ry1) * ROW_LEN + ADDR_W'(rx1);

    // Address only moves on real reads, keeping the ROM address bus quiet during gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_en   <= 1'b0;
            rom_addr <= '0;
            v2       <= 1'b0;
            inb2     <= 1'b0;
        end else begin
            rom_en <= v1 & inb1;
            if (v1 && inb1) begin
                rom_addr <= addr_c;
            end
            v2   <= v1;
            inb2 <= inb1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3   <= 1'b0;
            inb3 <= 1'b0;
        end else begin
            v3   <= v2;
            inb3 <= inb2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_valid <= 1'b0;
            rgb_out   <= '0;
        end else begin
            rgb_valid <= v3;
            if (v3) begin
                rgb_out <= inb3 ? rom_data : BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_image_rom_streamer.sv
// tb/tb_image_rom_streamer.sv - randomized self-checking bench for image_rom_streamer
module tb_image_rom_streamer;

    logic        clk, rst;
    logic        frame_start;
    logic [1:0]  img_sel;
    logic [9:0]  org_x, org_y;
    logic        pix_valid;
    logic [9:0]  pix_x, pix_y;

    logic        en0, en1, en2;
    logic [18:0] addr0, addr1;
    logic [19:0] addr2;
    logic [11:0] rd0, rd1, rd2;
    logic        rv0, rv1, rv2;
    logic [11:0] rgb0, rgb1, rgb2;

    int checks = 0;
    int failures = 0;

    image_rom_streamer dut0 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .img_sel(img_sel[0:0]),
        .org_x(org_x), .org_y(org_y), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .rom_en(en0), .rom_addr(addr0), .rom_data(rd0), .rgb_valid(rv0), .rgb_out(rgb0)
    );

    image_rom_streamer #(.SCALE_SHIFT(1)) dut1 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .img_sel(img_sel[0:0]),
        .org_x(org_x), .org_y(org_y), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .rom_en(en1), .rom_addr(addr1), .rom_data(rd1), .rgb_valid(rv1), .rgb_out(rgb1)
    );

    image_rom_streamer #(.NUM_IMG(2), .SEL_W(2), .ADDR_W(20)) dut2 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .img_sel(img_sel),
        .org_x(org_x), .org_y(org_y), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .rom_en(en2), .rom_addr(addr2), .rom_data(rd2), .rgb_valid(rv2), .rgb_out(rgb2)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(int a);
        return 12'(a * 37 + (a >> 12) * 11 + 1);
    endfunction

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk) if (en0) rd0 <= rom_f(int'(addr0));
    always @(posedge clk) if (en1) rd1 <= rom_f(int'(addr1));
    always @(posedge clk) if (en2) rd2 <= rom_f(int'(addr2));

    // Address of a screen pixel inside the selected 640x480 image, or -1 when it falls outside.
    function automatic int ref_addr(int x, int y, int ox, int oy, int sel, int sh);
        int rx, ry;
        if (x < ox || y < oy) return -1;
        rx = (x - ox) >> sh;
        ry = (y - oy) >> sh;
        if (rx >= 640 || ry >= 480) return -1;
        return sel * 640 * 480 + ry * 640 + rx;
    endfunction

    // Reference: what each sampled pixel should produce, delayed to when the outputs show it.
    int          q_a [3][3];
    bit          q_v [3];
    int          lat_ox, lat_oy;
    int          lat_sel [3];
    bit          e_en [3];
    int          e_addr [3];
    bit          e_rv;
    logic [11:0] e_rgb [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                for (int s = 0; s < 3; s++) q_a[d][s] <= -1;
                e_en[d]    <= 1'b0;
                e_addr[d]  <= 0;
                e_rgb[d]   <= 12'h000;
                lat_sel[d] <= 0;
            end
            for (int s = 0; s < 3; s++) q_v[s] <= 1'b0;
            e_rv   <= 1'b0;
            lat_ox <= 0;
            lat_oy <= 0;
        end else begin
            q_v[0] <= pix_valid;
            q_v[1] <= q_v[0];
            q_v[2] <= q_v[1];
            for (int d = 0; d < 3; d++) begin
                q_a[d][0] <= ref_addr(int'(pix_x), int'(pix_y), lat_ox, lat_oy, lat_sel[d], (d == 1) ? 1 : 0);
                q_a[d][1] <= q_a[d][0];
                q_a[d][2] <= q_a[d][1];
                e_en[d]   <= q_v[0] && (q_a[d][0] >= 0);
                if (q_v[0] && q_a[d][0] >= 0) e_addr[d] <= q_a[d][0];
                if (q_v[2]) e_rgb[d] <= (q_a[d][2] >= 0) ? rom_f(q_a[d][2]) : 12'h000;
            end
            e_rv <= q_v[2];
            if (frame_start) begin
                lat_ox     <= int'(org_x);
                lat_oy     <= int'(org_y);
                lat_sel[0] <= 0;
                lat_sel[1] <= 0;
                lat_sel[2] <= (int'(img_sel) < 2) ? int'(img_sel) : 0;
            end
        end
    end

    task automatic drive(bit v, int x, int y);
        pix_valid = v;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
    endtask

    task automatic frame(int s, int ox, int oy);
        @(negedge clk);
        frame_start = 1'b1;
        img_sel     = 2'(s);
        org_x       = 10'(ox);
        org_y       = 10'(oy);
        drive(0, 0, 0);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 12;
        if (en0 !== 1'b0)   begin failures++; $display("FAIL reset rom_en0 got=%b exp=0", en0); end
        if (addr0 !== '0)   begin failures++; $display("FAIL reset rom_addr0 got=%0d exp=0", addr0); end
        if (rv0 !== 1'b0)   begin failures++; $display("FAIL reset rgb_valid0 got=%b exp=0", rv0); end
        if (rgb0 !== '0)    begin failures++; $display("FAIL reset rgb_out0 got=%h exp=0", rgb0); end
        if (en1 !== 1'b0)   begin failures++; $display("FAIL reset rom_en1 got=%b exp=0", en1); end
        if (addr1 !== '0)   begin failures++; $display("FAIL reset rom_addr1 got=%0d exp=0", addr1); end
        if (rv1 !== 1'b0)   begin failures++; $display("FAIL reset rgb_valid1 got=%b exp=0", rv1); end
        if (rgb1 !== '0)    begin failures++; $display("FAIL reset rgb_out1 got=%h exp=0", rgb1); end
        if (en2 !== 1'b0)   begin failures++; $display("FAIL reset rom_en2 got=%b exp=0", en2); end
        if (addr2 !== '0)   begin failures++; $display("FAIL reset rom_addr2 got=%0d exp=0", addr2); end
        if (rv2 !== 1'b0)   begin failures++; $display("FAIL reset rgb_valid2 got=%b exp=0", rv2); end
        if (rgb2 !== '0)    begin failures++; $display("FAIL reset rgb_out2 got=%h exp=0", rgb2); end
        rst = 1'b0;
    endtask

    task automatic test_basic_addressing();
        int xs[6] = '{0, 1, 3, 0, 360, 639};
        int ys[6] = '{0, 0, 0, 1, 1, 479};
        int ea[6] = '{0, 1, 3, 640, 1000, 307199};
        frame(0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks += 4;
            if (en0 !== e_en[0]) begin failures++; $display("FAIL basic rom_en t=%0d got=%b exp=%b", i, en0, e_en[0]); end
            if (addr0 !== 19'(e_addr[0])) begin failures++; $display("FAIL basic rom_addr t=%0d got=%0d exp=%0d", i, addr0, e_addr[0]); end
            if (rv0 !== e_rv) begin failures++; $display("FAIL basic rgb_valid t=%0d got=%b exp=%b", i, rv0, e_rv); end
            if (rgb0 !== e_rgb[0]) begin failures++; $display("FAIL basic rgb_out t=%0d got=%h exp=%h", i, rgb0, e_rgb[0]); end
            if (i >= 2 && i < 8) begin
                checks++;
                if (en0 !== 1'b1 || addr0 !== 19'(ea[i-2])) begin
                    failures++; $display("FAIL basic addr_const t=%0d got=%0d en=%b exp=%0d", i, addr0, en0, ea[i-2]);
                end
            end
            if (i >= 4 && i < 10) begin
                checks++;
                if (rv0 !== 1'b1 || rgb0 !== rom_f(ea[i-4])) begin
                    failures++; $display("FAIL basic latency4 t=%0d got=%h v=%b exp=%h", i, rgb0, rv0, rom_f(ea[i-4]));
                end
            end
            if (i < 6) drive(1, xs[i], ys[i]); else drive(0, 0, 0);
        end
    endtask

    task automatic test_origin_bounds();
        int xs[5] = '{99, 100, 100, 739, 740};
        int ys[5] = '{50, 49, 50, 529, 50};
        int ea[5] = '{-1, -1, 0, 307199, -1};
        frame(0, 100, 50);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks += 4;
            if (en0 !== e_en[0]) begin failures++; $display("FAIL origin rom_en t=%0d got=%b exp=%b", i, en0, e_en[0]); end
            if (addr0 !== 19'(e_addr[0])) begin failures++; $display("FAIL origin rom_addr t=%0d got=%0d exp=%0d", i, addr0, e_addr[0]); end
            if (rv0 !== e_rv) begin failures++; $display("FAIL origin rgb_valid t=%0d got=%b exp=%b", i, rv0, e_rv); end
            if (rgb0 !== e_rgb[0]) begin failures++; $display("FAIL origin rgb_out t=%0d got=%h exp=%h", i, rgb0, e_rgb[0]); end
            if (i >= 2 && i < 7) begin
                checks++;
                if ((ea[i-2] < 0 && en0 !== 1'b0) || (ea[i-2] >= 0 && (en0 !== 1'b1 || addr0 !== 19'(ea[i-2])))) begin
                    failures++; $display("FAIL origin addr_const t=%0d got=%0d en=%b exp=%0d", i, addr0, en0, ea[i-2]);
                end
            end
            if (i >= 4 && i < 9 && ea[i-4] < 0) begin
                checks++;
                if (rv0 !== 1'b1 || rgb0 !== 12'h000) begin
                    failures++; $display("FAIL origin bg_fill t=%0d got=%h v=%b exp=000", i, rgb0, rv0);
                end
            end
            if (i < 5) drive(1, xs[i], ys[i]); else drive(0, 0, 0);
        end
    endtask

    task automatic test_gaps_random();
        bit pat[8] = '{1, 1, 0, 1, 0, 0, 1, 1};
        bit vv[32];
        int ox = $urandom_range(0, 200);
        int oy = $urandom_range(0, 200);
        for (int k = 0; k < 32; k++) vv[k] = (k < 8) ? pat[k] : 1'($urandom_range(0, 1));
        frame(0, ox, oy);
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            checks += 4;
            if (en0 !== e_en[0]) begin failures++; $display("FAIL gaps rom_en t=%0d got=%b exp=%b", i, en0, e_en[0]); end
            if (addr0 !== 19'(e_addr[0])) begin failures++; $display("FAIL gaps rom_addr t=%0d got=%0d exp=%0d", i, addr0, e_addr[0]); end
            if (rv0 !== e_rv) begin failures++; $display("FAIL gaps rgb_valid t=%0d got=%b exp=%b", i, rv0, e_rv); end
            if (rgb0 !== e_rgb[0]) begin failures++; $display("FAIL gaps rgb_out t=%0d got=%h exp=%h", i, rgb0, e_rgb[0]); end
            if (i >= 4 && i < 36) begin
                checks++;
                if (rv0 !== vv[i-4]) begin failures++; $display("FAIL gaps valid_pattern t=%0d got=%b exp=%b", i, rv0, vv[i-4]); end
            end
            if (i < 32) drive(vv[i], $urandom_range(0, 900), $urandom_range(0, 600)); else drive(0, 0, 0);
        end
    endtask

    task automatic test_scale();
        int xs[6] = '{0, 1, 2, 3, 1023, 0};
        int ys[6] = '{0, 0, 0, 3, 959, 960};
        int ea[6] = '{0, 0, 1, 641, 307071, -1};
        frame(0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks += 4;
            if (en1 !== e_en[1]) begin failures++; $display("FAIL scale rom_en t=%0d got=%b exp=%b", i, en1, e_en[1]); end
            if (addr1 !== 19'(e_addr[1])) begin failures++; $display("FAIL scale rom_addr t=%0d got=%0d exp=%0d", i, addr1, e_addr[1]); end
            if (rv1 !== e_rv) begin failures++; $display("FAIL scale rgb_valid t=%0d got=%b exp=%b", i, rv1, e_rv); end
            if (rgb1 !== e_rgb[1]) begin failures++; $display("FAIL scale rgb_out t=%0d got=%h exp=%h", i, rgb1, e_rgb[1]); end
            if (i >= 2 && i < 8) begin
                checks++;
                if ((ea[i-2] < 0 && en1 !== 1'b0) || (ea[i-2] >= 0 && (en1 !== 1'b1 || addr1 !== 19'(ea[i-2])))) begin
                    failures++; $display("FAIL scale addr_const t=%0d got=%0d en=%b exp=%0d", i, addr1, en1, ea[i-2]);
                end
            end
            if (i < 6) drive(1, xs[i], ys[i]); else drive(0, 0, 0);
        end
    endtask

    task automatic test_multi_image();
        int xs[6] = '{0, 5, 0, 639, 1, 639};
        int ys[6] = '{0, 2, 0, 479, 0, 479};
        int ea[6] = '{307200, 308485, 307200, 307199, 1, 614399};
        frame(1, 0, 0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks += 4;
            if (en2 !== e_en[2]) begin failures++; $display("FAIL multi rom_en t=%0d got=%b exp=%b", i, en2, e_en[2]); end
            if (addr2 !== 20'(e_addr[2])) begin failures++; $display("FAIL multi rom_addr t=%0d got=%0d exp=%0d", i, addr2, e_addr[2]); end
            if (rv2 !== e_rv) begin failures++; $display("FAIL multi rgb_valid t=%0d got=%b exp=%b", i, rv2, e_rv); end
            if (rgb2 !== e_rgb[2]) begin failures++; $display("FAIL multi rgb_out t=%0d got=%h exp=%h", i, rgb2, e_rgb[2]); end
            if (i >= 2 && i < 8) begin
                checks++;
                if (en2 !== 1'b1 || addr2 !== 20'(ea[i-2])) begin
                    failures++; $display("FAIL multi addr_const t=%0d got=%0d en=%b exp=%0d", i, addr2, en2, ea[i-2]);
                end
            end
            frame_start = (i == 2 || i == 4);
            if (i == 1) img_sel = 2'd0;
            if (i == 2) img_sel = 2'd3;
            if (i == 4) img_sel = 2'd1;
            if (i < 6) drive(1, xs[i], ys[i]); else drive(0, 0, 0);
        end
    endtask

    task automatic test_reset_in_flight();
        frame(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 2;
            if (en0 !== e_en[0]) begin failures++; $display("FAIL flight rom_en t=%0d got=%b exp=%b", i, en0, e_en[0]); end
            if (rv0 !== e_rv) begin failures++; $display("FAIL flight rgb_valid t=%0d got=%b exp=%b", i, rv0, e_rv); end
            if (i < 3) drive(1, i * 10, 5); else drive(0, 0, 0);
        end
        checks++;
        if (rv0 !== 1'b1 || en0 !== 1'b1) begin failures++; $display("FAIL flight pre_reset v=%b en=%b exp=1 1", rv0, en0); end
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (en0 !== 1'b0)  begin failures++; $display("FAIL flight async rom_en got=%b exp=0", en0); end
        if (rv0 !== 1'b0)  begin failures++; $display("FAIL flight async rgb_valid got=%b exp=0", rv0); end
        if (addr0 !== '0)  begin failures++; $display("FAIL flight async rom_addr got=%0d exp=0", addr0); end
        if (rgb0 !== '0)   begin failures++; $display("FAIL flight async rgb_out got=%h exp=0", rgb0); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks += 2;
            if (rv0 !== 1'b0 || rv1 !== 1'b0 || rv2 !== 1'b0) begin
                failures++; $display("FAIL flight post_reset_valid t=%0d got=%b%b%b exp=000", i, rv0, rv1, rv2);
            end
            if (en0 !== 1'b0 || en2 !== 1'b0) begin
                failures++; $display("FAIL flight post_reset_en t=%0d got=%b%b exp=00", i, en0, en2);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        frame_start = 1'b0;
        img_sel = '0;
        org_x = '0;
        org_y = '0;
        drive(0, 0, 0);
        test_reset();
        test_basic_addressing();
        test_origin_bounds();
        test_gaps_random();
        test_scale();
        test_multi_image();
        test_reset_in_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
